// File: rtl/core_cp_ctl.sv
// Core-side coprocessor port controller: EXE dispatch handshake, destination
// scoreboard, outstanding-result counter and one-entry writeback buffer.
module core_cp_ctl #(
  parameter int XLEN      = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 de_val,
  input  logic                 de_adv,
  input  logic                 cp_dec_val,
  input  logic [1:0]           cp_dec_src_val,
  input  logic [1:0][4:0]      cp_dec_src_xidx,
  input  logic                 cp_dec_dst_val,
  input  logic [4:0]           cp_dec_dst_xidx,
  output logic                 de_cp_stall,
  input  logic [XLEN-1:0]      exe_opa,
  input  logic [XLEN-1:0]      exe_opb,
  input  logic                 exe_kill,
  output logic                 core_disp_val,
  input  logic                 core_disp_rdy,
  output logic [XLEN-1:0]      core_disp_opa,
  output logic [XLEN-1:0]      core_disp_opb,
  output logic                 exe_cp_stall,
  input  logic                 cp_res_val,
  output logic                 cp_res_rdy,
  input  logic [4:0]           cp_res_rd,
  input  logic [XLEN-1:0]      cp_res,
  output logic                 wb_val,
  output logic [4:0]           wb_rd,
  output logic [XLEN-1:0]      wb_data,
  input  logic                 wb_gnt,
  output logic [3:0]           outst_cnt
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

  logic        exe_cp_v;
  logic        exe_rd_v;
  logic [4:0]  exe_rd;
  logic [31:0] pend;
  logic [31:0] busy_vec;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;
  logic        handshake;
  logic        retire;
  logic        res_acc;
  logic        res_drop;
  logic        cnt_inc;
  logic [4:0]  cnt_sum;

  assign core_disp_val = exe_cp_v & ((outst_cnt < MAX_CNT) | ~exe_rd_v);
  assign handshake     = core_disp_val & core_disp_rdy;
  assign exe_cp_stall  = exe_cp_v & ~handshake;
  assign core_disp_opa = exe_opa;
  assign core_disp_opb = exe_opb;

  assign retire     = wb_val & wb_gnt;
  assign cp_res_rdy = ~wb_val | wb_gnt;
  assign res_acc    = cp_res_val & cp_res_rdy;
  assign res_drop   = res_acc & (cp_res_rd == 5'd0);
  assign cnt_inc    = handshake & exe_rd_v;

  // A register is busy if its result is outstanding or the EXE instruction writes it.
  always_comb begin
    busy_vec = pend;
    if (exe_cp_v && exe_rd_v) busy_vec[exe_rd] = 1'b1;
    busy_vec[0] = 1'b0;
  end

  always_comb begin
    de_cp_stall = 1'b0;
    if (de_val && cp_dec_val) begin
      if (cp_dec_src_val[0] && busy_vec[cp_dec_src_xidx[0]]) de_cp_stall = 1'b1;
      if (cp_dec_src_val[1] && busy_vec[cp_dec_src_xidx[1]]) de_cp_stall = 1'b1;
      if (cp_dec_dst_val && busy_vec[cp_dec_dst_xidx])       de_cp_stall = 1'b1;
    end
  end

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (handshake && exe_rd_v && exe_rd != 5'd0) set_vec[exe_rd] = 1'b1;
    if (retire) clr_vec[wb_rd] = 1'b1;
    cnt_sum = {1'b0, outst_cnt} + {4'd0, cnt_inc} - {4'd0, retire} - {4'd0, res_drop};
  end

  // Kill wins over a reload; a dispatched entry empties unless DE refills it.
  always_ff @(posedge clk) begin
    if (rst) begin
      exe_cp_v <= 1'b0;
      exe_rd_v <= 1'b0;
      exe_rd   <= 5'd0;
    end else if (exe_kill) begin
      exe_cp_v <= 1'b0;
      exe_rd_v <= 1'b0;
    end else if (de_adv) begin
      exe_cp_v <= de_val & cp_dec_val & ~de_cp_stall;
      exe_rd_v <= cp_dec_dst_val;
      exe_rd   <= cp_dec_dst_xidx;
    end else if (handshake) begin
      exe_cp_v <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= '0;
      outst_cnt <= 4'd0;
    end else begin
      pend      <= (pend & ~clr_vec) | set_vec;
      outst_cnt <= cnt_sum[3:0];
      assert ((set_vec & clr_vec) == '0);
      assert (({1'b0, outst_cnt} + {4'd0, cnt_inc}) >= ({4'd0, retire} + {4'd0, res_drop}));
      assert (outst_cnt <= MAX_CNT);
    end
  end

  // Results for x0 are acknowledged but never reach the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_val  <= 1'b0;
      wb_rd   <= 5'd0;
      wb_data <= '0;
    end else begin
      if (retire) wb_val <= 1'b0;
      if (res_acc && cp_res_rd != 5'd0) begin
        wb_val  <= 1'b1;
        wb_rd   <= cp_res_rd;
        wb_data <= cp_res;
      end
    end
  end

endmodule

// File: tb/tb_core_cp_ctl.sv
// Randomized bench for core_cp_ctl: a queue-based coprocessor/core model
// predicts stalls, dispatch, outstanding count and writeback each cycle.
module tb_core_cp_ctl;

  localparam int XLEN      = 32;
  localparam int MAX_OUTST = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            de_val = 1'b0;
  logic            de_adv = 1'b0;
  logic            cp_dec_val = 1'b0;
  logic [1:0]      cp_dec_src_val = '0;
  logic [1:0][4:0] cp_dec_src_xidx = '0;
  logic            cp_dec_dst_val = 1'b0;
  logic [4:0]      cp_dec_dst_xidx = '0;
  logic            de_cp_stall;
  logic [XLEN-1:0] exe_opa = '0;
  logic [XLEN-1:0] exe_opb = '0;
  logic            exe_kill = 1'b0;
  logic            core_disp_val;
  logic            core_disp_rdy = 1'b0;
  logic [XLEN-1:0] core_disp_opa;
  logic [XLEN-1:0] core_disp_opb;
  logic            exe_cp_stall;
  logic            cp_res_val = 1'b0;
  logic            cp_res_rdy;
  logic [4:0]      cp_res_rd = '0;
  logic [XLEN-1:0] cp_res = '0;
  logic            wb_val;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_gnt = 1'b0;
  logic [3:0]      outst_cnt;

  core_cp_ctl #(.XLEN(XLEN), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .rst(rst),
    .de_val(de_val), .de_adv(de_adv), .cp_dec_val(cp_dec_val),
    .cp_dec_src_val(cp_dec_src_val), .cp_dec_src_xidx(cp_dec_src_xidx),
    .cp_dec_dst_val(cp_dec_dst_val), .cp_dec_dst_xidx(cp_dec_dst_xidx),
    .de_cp_stall(de_cp_stall), .exe_opa(exe_opa), .exe_opb(exe_opb),
    .exe_kill(exe_kill), .core_disp_val(core_disp_val), .core_disp_rdy(core_disp_rdy),
    .core_disp_opa(core_disp_opa), .core_disp_opb(core_disp_opb),
    .exe_cp_stall(exe_cp_stall), .cp_res_val(cp_res_val), .cp_res_rdy(cp_res_rdy),
    .cp_res_rd(cp_res_rd), .cp_res(cp_res), .wb_val(wb_val), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_gnt(wb_gnt), .outst_cnt(outst_cnt)
  );

  always #5 clk = ~clk;

  // Reference state: instructions accepted by the CP awaiting a result,
  // the instruction sitting in EXE, and the result waiting for the register file.
  logic [4:0]      cp_q[$];
  logic            m_exe_v = 1'b0;
  logic            m_exe_rdv = 1'b0;
  logic [4:0]      m_exe_rd = '0;
  logic            m_wb_v = 1'b0;
  logic [4:0]      m_wb_rd = '0;
  logic [XLEN-1:0] m_wb_data = '0;
  logic            res_hold = 1'b0;
  int              p_rdy = 70;
  int              p_gnt = 60;
  int              p_res = 50;
  int              n_checks = 0;
  int              n_errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 30)
        $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit modelBusy(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (m_wb_v && m_wb_rd == r) return 1'b1;
    foreach (cp_q[k]) if (cp_q[k] == r) return 1'b1;
    if (m_exe_v && m_exe_rdv && m_exe_rd == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic applyStimulus();
    int cnt;
    de_val             = ($urandom_range(99) < 80);
    cp_dec_val         = ($urandom_range(99) < 70);
    cp_dec_src_val     = 2'($urandom);
    cp_dec_src_xidx[0] = 5'($urandom_range(7));
    cp_dec_src_xidx[1] = 5'($urandom_range(7));
    cp_dec_dst_val     = ($urandom_range(99) < 75);
    cp_dec_dst_xidx    = 5'($urandom_range(7));
    exe_opa            = $urandom;
    exe_opb            = $urandom;
    exe_kill           = ($urandom_range(99) < 3);
    core_disp_rdy      = ($urandom_range(99) < p_rdy);
    wb_gnt             = ($urandom_range(99) < p_gnt);
    if (!res_hold && cp_q.size() > 0 && $urandom_range(99) < p_res) begin
      res_hold  = 1'b1;
      cp_res_rd = cp_q[0];
      cp_res    = $urandom;
    end
    cp_res_val = res_hold;
    cnt = cp_q.size() + int'(m_wb_v);
    de_adv = ($urandom_range(99) < 85);
    if (m_exe_v && !((cnt < MAX_OUTST || !m_exe_rdv) && core_disp_rdy)) de_adv = 1'b0;
  endtask

  task automatic step();
    logic exp_haz, exp_disp, hs, exp_rdy, acc, retire;
    int   exp_cnt;
    @(negedge clk);
    applyStimulus();
    #1;
    exp_cnt  = cp_q.size() + int'(m_wb_v);
    exp_haz  = de_val && cp_dec_val &&
               ((cp_dec_src_val[0] && modelBusy(cp_dec_src_xidx[0])) ||
                (cp_dec_src_val[1] && modelBusy(cp_dec_src_xidx[1])) ||
                (cp_dec_dst_val && modelBusy(cp_dec_dst_xidx)));
    exp_disp = m_exe_v && (exp_cnt < MAX_OUTST || !m_exe_rdv);
    hs       = exp_disp && core_disp_rdy;
    exp_rdy  = !m_wb_v || wb_gnt;
    acc      = cp_res_val && exp_rdy;
    retire   = m_wb_v && wb_gnt;

    checkOutput("de_cp_stall", 32'(de_cp_stall), 32'(exp_haz));
    checkOutput("core_disp_val", 32'(core_disp_val), 32'(exp_disp));
    checkOutput("exe_cp_stall", 32'(exe_cp_stall), 32'(m_exe_v && !hs));
    checkOutput("cp_res_rdy", 32'(cp_res_rdy), 32'(exp_rdy));
    checkOutput("outst_cnt", 32'(outst_cnt), exp_cnt);
    checkOutput("wb_val", 32'(wb_val), 32'(m_wb_v));
    if (exp_disp) begin
      checkOutput("core_disp_opa", core_disp_opa, exe_opa);
      checkOutput("core_disp_opb", core_disp_opb, exe_opb);
    end
    if (m_wb_v) begin
      checkOutput("wb_rd", 32'(wb_rd), 32'(m_wb_rd));
      checkOutput("wb_data", wb_data, m_wb_data);
    end

    if (acc) begin
      void'(cp_q.pop_front());
      res_hold = 1'b0;
    end
    if (hs && m_exe_rdv) cp_q.push_back(m_exe_rd);
    if (retire) m_wb_v = 1'b0;
    if (acc && cp_res_rd != 5'd0) begin
      m_wb_v    = 1'b1;
      m_wb_rd   = cp_res_rd;
      m_wb_data = cp_res;
    end
    if (exe_kill) m_exe_v = 1'b0;
    else if (de_adv) begin
      m_exe_v   = de_val && cp_dec_val && !exp_haz;
      m_exe_rdv = cp_dec_dst_val;
      m_exe_rd  = cp_dec_dst_xidx;
    end else if (hs) m_exe_v = 1'b0;
  endtask

  // Reset is applied with live traffic, including a result offered in the reset cycle.
  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus();
    cp_res_val = 1'b1;
    cp_res_rd  = 5'd3;
    de_adv     = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cp_q.delete();
    res_hold   = 1'b0;
    m_exe_v    = 1'b0;
    m_wb_v     = 1'b0;
    m_wb_rd    = '0;
    m_wb_data  = '0;
    de_val     = 1'b0;
    de_adv     = 1'b0;
    cp_res_val = 1'b0;
    core_disp_rdy = 1'b0;
    wb_gnt     = 1'b0;
    exe_kill   = 1'b0;
    #1;
    checkOutput("rst_wb_val", 32'(wb_val), 32'd0);
    checkOutput("rst_wb_rd", 32'(wb_rd), 32'd0);
    checkOutput("rst_wb_data", wb_data, 32'd0);
    checkOutput("rst_outst_cnt", 32'(outst_cnt), 32'd0);
    checkOutput("rst_disp_val", 32'(core_disp_val), 32'd0);
    checkOutput("rst_exe_stall", 32'(exe_cp_stall), 32'd0);
    checkOutput("rst_de_stall", 32'(de_cp_stall), 32'd0);
    checkOutput("rst_res_rdy", 32'(cp_res_rdy), 32'd1);
  endtask

  initial begin
    for (int phase = 0; phase < 4; phase++) begin
      case (phase)
        0: begin p_rdy = 70; p_gnt = 60; p_res = 50; end
        1: begin p_rdy = 90; p_gnt = 70; p_res = 5;  end
        2: begin p_rdy = 80; p_gnt = 50; p_res = 95; end
        default: begin p_rdy = 30; p_gnt = 90; p_res = 60; end
      endcase
      doReset();
      for (int c = 0; c < 600; c++) step();
    end
    $display("[TB] phases complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/core_cp_ctl.md
# core_cp_ctl

Core-side controller for the coprocessor (CP) port. It sits in the scalar core pipeline opposite the coprocessor. It consumes the CP decode outputs in DE and drives the dispatch handshake in EXE. It tracks outstanding CP destination registers in a scoreboard, accepts CP results through a one-entry writeback buffer, and stalls the core on register hazards or when too many results are outstanding.

## Interface
Parameters:
- XLEN, default riscv::XLEN, data width of operands and results.
- MAX_OUTST, default 4, maximum dispatched CP instructions with rd still awaiting a result (range 1..15).

Ports:
- clk  in  1  sole clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- de_val  in  1  valid instruction in DE (core_ibuf_val to CP).
- de_adv  in  1  core advances DE into EXE this cycle.
- cp_dec_val  in  1  CP claims the DE instruction.
- cp_dec_src_val  in  2  rs1/rs2 valid.
- cp_dec_src_xidx  in  2x5  rs1/rs2 indices.
- cp_dec_dst_val  in  1  rd valid.
- cp_dec_dst_xidx  in  5  rd index.
- de_cp_stall  out  1  hold the DE instruction (hazard).
- exe_opa, exe_opb  in  XLEN  operands read by the core.
- exe_kill  in  1  flush of the EXE instruction.
- core_disp_val  out  1  dispatch request.
- core_disp_rdy  in  1  CP accepts dispatch.
- core_disp_opa, core_disp_opb  out  XLEN  operands, equal to exe_opa/exe_opb.
- exe_cp_stall  out  1  hold EXE (dispatch not yet completed).
- cp_res_val  in  1  CP result valid.
- cp_res_rdy  out  1  result accepted.
- cp_res_rd  in  5  result destination.
- cp_res  in  XLEN  result data.
- wb_val  out  1  writeback request to the register file.
- wb_rd  out  5  writeback index.
- wb_data  out  XLEN  writeback data.
- wb_gnt  in  1  register-file write port granted.
- outst_cnt  out  4  outstanding rd count.

## Operation
- EXE register captures cp_v = de_val&cp_dec_val&!de_cp_stall, rd_v, and rd when de_adv. A stalled or non-CP instruction loads cp_v=0. The register is cleared on exe_kill.
- Dispatch:
  - core_disp_val = exe cp_v & (outst_cnt<MAX_OUTST | !exe rd_v).
  - Handshake happens when core_disp_val & core_disp_rdy.
  - exe_cp_stall = exe cp_v & !handshake.
  - On handshake the EXE entry clears unless de_adv reloads it.
- Scoreboard, 32-bit pend:
  - Set pend[rd] on handshake when rd_v and rd!=0.
  - Clear pend[wb_rd] when wb_val&wb_gnt.
  - Set and clear of the same bit in one cycle → set wins. This cannot legally occur; flag it with an assertion.
- Hazard: de_cp_stall = de_val & cp_dec_val & (any valid src or dst index with pend set, or equal to the EXE rd while exe cp_v&rd_v, index!=0).
- Counter:
  - +1 on handshake with rd_v.
  - −1 on wb retire.
  - Both in one cycle → unchanged.
  - Never exceeds MAX_OUTST. Never underflows (assert).
- Writeback buffer: one entry.
  - cp_res_rdy = !wb_val | wb_gnt.
  - Captures cp_res_rd/cp_res on cp_res_val&cp_res_rdy.
  - Retire and refill can happen in the same cycle.
  - A result with rd=0 is accepted and discarded (not loaded; still decrements the count).

## Timing
- All outputs are registered except de_cp_stall, core_disp_val, core_disp_opa/opb, exe_cp_stall and cp_res_rdy, which are combinational from state and inputs.
- Reset values: pend=0, outst_cnt=0, exe cp_v=0, wb_val=0, wb_rd=0, wb_data=0. Hence core_disp_val=0, stalls=0, cp_res_rdy=1.
- Latency:
  - DE accept → dispatch request in the next cycle.
  - Result handshake → wb_val in the next cycle.
  - wb_gnt → pend cleared; a dependent DE instruction unstalls the cycle after.
- Full back-to-back results are sustained while wb_gnt is held high.
- Reset mid-dispatch drops the EXE instruction and all pending state. Results arriving in the reset cycle are ignored.

## Test plan
- Single CP instr rd=5, opa=0x11, opb=0x22, disp_rdy=1 → one-cycle disp_val with the operands; pend[5]=1, outst_cnt=1; result 0xABCD for rd 5 → wb_val, wb_rd=5, wb_data=0xABCD next cycle; gnt → pend[5]=0, cnt=0.
- Dependent instr rs1=5 following the rd=5 instr → de_cp_stall high until the cycle after the wb_gnt for rd 5.
- Five rd-writing dispatches with MAX_OUTST=4 and no results → fifth holds disp_val low with exe_cp_stall=1; one retire → fifth dispatches the next cycle; cnt stays 4.
- disp_rdy low for 3 cycles → disp_val and operands held stable, exe_cp_stall=1 for 3 cycles, single handshake.
- Results every cycle with wb_gnt toggling 1,0,1 → cp_res_rdy=0 exactly in the cycle where wb_val=1 and wb_gnt=0; no result lost or duplicated.
- Simultaneous dispatch with rd and retire → outst_cnt unchanged; rst asserted mid-stream → all outputs at reset values next cycle.
